// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, datapath defaults and the hazard scoreboard entry.
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 4;
  // Entry rd field is sized for the widest supported register file; indices are zero-extended.
  localparam int SB_RD_W    = 8;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// Youngest-match priority picker for one source operand: forward select or stall request.
module hazard_fwd_sel import cpu_pkg::*; #(
  parameter int DEPTH     = 4,
  parameter int EX_STAGES = 2,
  parameter int REG_AW    = 4,
  parameter int SEL_W     = 3
) (
  input  logic                  i_req,
  input  logic [REG_AW-1:0]     i_rs,
  input  sb_entry_t [DEPTH-1:0] i_sb,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_stall_req
);
  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    o_sel       = SEL_W'(FWD_REGFILE);
    o_stall_req = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_req && i_sb[k-1].valid && i_sb[k-1].rd == SB_RD_W'(i_rs)) begin
        if (k >= (i_sb[k-1].is_load ? EX_STAGES + 2 : EX_STAGES + 1)) begin
          o_sel       = SEL_W'(k);
          o_stall_req = 1'b0;
        end else begin
          o_sel       = SEL_W'(FWD_REGFILE);
          o_stall_req = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection / forwarding unit: shift-register scoreboard EX1..EXn, MEM, WB.
// Optional stall performance counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_scoreboard import cpu_pkg::*; #(
  parameter  int DATA_W      = CPU_DATA_W,
  parameter  int NUM_REGS    = 16,
  parameter  int REG_AW      = CPU_REG_AW,
  parameter  int EX_STAGES   = 2,
  parameter  int FLUSH_DEPTH = 1,
  localparam int DEPTH       = EX_STAGES + 2,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_id_valid,
  input  logic [REG_AW-1:0]       i_id_rs1,
  input  logic [REG_AW-1:0]       i_id_rs2,
  input  logic                    i_id_rs1_used,
  input  logic                    i_id_rs2_used,
  input  logic [REG_AW-1:0]       i_id_rd,
  input  logic                    i_id_reg_write,
  input  logic                    i_id_mem_read,
  input  logic                    i_flush,
  input  logic [DEPTH*DATA_W-1:0] i_stage_data,
  output logic                    o_stall,
  output logic [SEL_W-1:0]        o_fwd_sel1,
  output logic [SEL_W-1:0]        o_fwd_sel2,
  output logic [DATA_W-1:0]       o_fwd_data1,
  output logic [DATA_W-1:0]       o_fwd_data2,
  output logic [15:0]             o_stall_cycles
);
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > EX_STAGES || EX_STAGES < 1 ||
      NUM_REGS > (1 << REG_AW) || REG_AW > SB_RD_W) begin : g_param_chk
    $error("hazard_scoreboard: illegal parameter combination");
  end

  sb_entry_t [DEPTH-1:0] r_sb;
  sb_entry_t [DEPTH-1:0] w_sb_nxt;
  logic                  w_req1, w_req2, w_stall;
  logic [SEL_W-1:0]      w_sel1, w_sel2;

  hazard_fwd_sel #(.DEPTH(DEPTH), .EX_STAGES(EX_STAGES), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_src1 (
    .i_req(i_id_valid & i_id_rs1_used), .i_rs(i_id_rs1), .i_sb(r_sb),
    .o_sel(w_sel1), .o_stall_req(w_req1)
  );
  hazard_fwd_sel #(.DEPTH(DEPTH), .EX_STAGES(EX_STAGES), .REG_AW(REG_AW), .SEL_W(SEL_W)) u_src2 (
    .i_req(i_id_valid & i_id_rs2_used), .i_rs(i_id_rs2), .i_sb(r_sb),
    .o_sel(w_sel2), .o_stall_req(w_req2)
  );

  // A redirect kills the ID instruction anyway, so it never needs to wait.
  assign w_stall    = (w_req1 | w_req2) & ~i_flush;
  assign o_stall    = w_stall;
  assign o_fwd_sel1 = w_sel1;
  assign o_fwd_sel2 = w_sel2;

  always_comb begin
    o_fwd_data1 = '0;
    o_fwd_data2 = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (w_sel1 == SEL_W'(k)) o_fwd_data1 = i_stage_data[(k-1)*DATA_W +: DATA_W];
      if (w_sel2 == SEL_W'(k)) o_fwd_data2 = i_stage_data[(k-1)*DATA_W +: DATA_W];
    end
  end

  // Flushed young entries are zeroed in place, so they never reach the next position.
  always_comb begin
    w_sb_nxt[0] = '0;
    if (i_id_valid && i_id_reg_write && !w_stall && !i_flush)
      w_sb_nxt[0] = '{valid: 1'b1, rd: SB_RD_W'(i_id_rd), is_load: i_id_mem_read};
    for (int k = 1; k < DEPTH; k++)
      w_sb_nxt[k] = (i_flush && k <= FLUSH_DEPTH) ? '0 : r_sb[k-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sb <= '0;
    else          r_sb <= w_sb_nxt;
  end

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] r_stall_cycles;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stall_cycles <= '0;
    else if (w_stall && r_stall_cycles != 16'hFFFF)
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end
  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench for hazard_scoreboard with default parameters (EX_STAGES=2, DEPTH=4).
module tb_hazard_scoreboard;
  localparam int DW = 16, AW = 4, DEPTH = 4, SW = 3;
`ifdef HAZ_STALL_CNT_EN
  localparam logic [15:0] CNT5 = 16'd5;
`else
  localparam logic [15:0] CNT5 = 16'd0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  id_valid, rs1_used, rs2_used, reg_write, mem_read, flush;
  logic [AW-1:0]         rs1, rs2, rd;
  logic [DEPTH*DW-1:0]   stage_data;
  logic                  stall;
  logic [SW-1:0]         sel1, sel2;
  logic [DW-1:0]         data1, data2;
  logic [15:0]           stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd(rd), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
    .i_flush(flush), .i_stage_data(stage_data),
    .o_stall(stall), .o_fwd_sel1(sel1), .o_fwd_sel2(sel2),
    .o_fwd_data1(data1), .o_fwd_data2(data2), .o_stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic          stall;
    logic [SW-1:0] s1, s2;
    logic [DW-1:0] d1, d2;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // Position k holds 16'h003F + k, so position 3 is 16'h0042.
  function automatic logic [DW-1:0] pos_data(input int k);
    return (k == 0) ? '0 : DW'(16'h003F + k);
  endfunction

  function automatic exp_t obs();
    return '{stall: stall, s1: sel1, s2: sel2, d1: data1, d2: data2};
  endfunction

  task automatic apply(input logic v, input logic [AW-1:0] a1, input logic u1,
                       input logic [AW-1:0] a2, input logic u2, input logic [AW-1:0] d,
                       input logic rw, input logic ld, input logic fl,
                       input logic es, input int s1, input int s2);
    id_valid = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
    rd = d; reg_write = rw; mem_read = ld; flush = fl;
    q.push_back('{stall: es, s1: SW'(s1), s2: SW'(s2), d1: pos_data(s1), d2: pos_data(s2)});
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    exp_t e, o;
    apply(1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0);
    #2;
    e = q.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_outputs got %h exp %h", o, e); end
    checks++;
    if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_counter got %0d exp 0", stall_cycles); end
    @(negedge clk); rst_n = 1'b1;
    apply(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    e = q.pop_front(); o = obs(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_empty got %h exp %h", o, e); end
    @(negedge clk);
  endtask

  task automatic test_alu_use();
    exp_t e, o;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       apply(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
        1, 2:    apply(1, 3, 1, 1, 1, 5, 1, 0, 0, 1, 0, 0);
        3:       apply(1, 3, 1, 1, 1, 5, 1, 0, 0, 0, 3, 0);
        default: idle();
      endcase
      #2;
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL alu_use row%0d got %h exp %h", i, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    exp_t e, o;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       apply(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        1, 2, 3: apply(1, 4, 1, 4, 1, 6, 1, 0, 0, 1, 0, 0);
        4:       apply(1, 4, 1, 4, 1, 6, 1, 0, 0, 0, 4, 4);
        default: idle();
      endcase
      #2;
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL load_use row%0d got %h exp %h", i, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_shadow();
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 2:    apply(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        1:       apply(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        3:       apply(1, 2, 1, 7, 1, 9, 1, 0, 0, 1, 0, 0);
        4:       apply(1, 2, 1, 7, 1, 9, 1, 0, 0, 1, 0, 3);
        5:       apply(1, 2, 1, 7, 1, 9, 1, 0, 0, 0, 3, 4);
        default: idle();
      endcase
      #2;
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL shadow row%0d got %h exp %h", i, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_unused();
    exp_t e, o;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       apply(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        1:       apply(1, 10, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        2:       apply(1, 11, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0);
        3:       apply(0, 9, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        4:       apply(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        default: idle();
      endcase
      #2;
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL unused row%0d got %h exp %h", i, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    exp_t e, o;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       apply(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0);
        1:       apply(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0);
        2:       apply(1, 8, 1, 11, 1, 12, 1, 0, 1, 0, 0, 0);
        3:       apply(1, 8, 1, 11, 1, 12, 1, 0, 0, 0, 3, 0);
        default: idle();
      endcase
      #2;
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL flush row%0d got %h exp %h", i, o, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_counter_reset();
    exp_t e, o;
    rst_n = 1'b0;
    #2;
    checks++;
    if (stall_cycles !== 16'd0) begin failures++; $display("FAIL cnt_clear got %0d exp 0", stall_cycles); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      case (i)
        0:       apply(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        1, 2, 3: apply(1, 4, 1, 4, 1, 6, 0, 0, 0, 1, 0, 0);
        4:       apply(1, 4, 1, 4, 1, 6, 0, 0, 0, 0, 4, 4);
        5, 9:    apply(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        6, 7, 10: apply(1, 1, 1, 0, 0, 6, 0, 0, 0, 1, 0, 0);
        default: apply(1, 1, 1, 0, 0, 6, 0, 0, 0, 0, 3, 0);
      endcase
      #2;
      e = q.pop_front(); o = obs(); checks++;
      if (o !== e) begin failures++; $display("FAIL counter row%0d got %h exp %h", i, o, e); end
      if (i == 8) begin
        checks++;
        if (stall_cycles !== CNT5) begin
          failures++; $display("FAIL stall_count got %0d exp %0d", stall_cycles, CNT5);
        end
      end
      if (i < 10) @(negedge clk);
    end
    // Consumer still stalled: drop reset in the middle of the cycle.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, sel1, stall_cycles} !== {1'b0, 3'd0, 16'd0}) begin
      failures++; $display("FAIL async_reset got stall=%b sel1=%0d cnt=%0d exp 0/0/0", stall, sel1, stall_cycles);
    end
    @(negedge clk); rst_n = 1'b1;
    #2;
    checks++;
    if ({stall, sel1} !== {1'b0, 3'd0}) begin
      failures++; $display("FAIL post_reset_empty got stall=%b sel1=%0d exp 0/0", stall, sel1);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) stage_data[j*DW +: DW] = DW'(16'h0040 + j);
    rst_n = 1'b0;
    idle();
    void'(q.pop_front());
    test_reset();
    test_alu_use();
    test_load_use();
    test_shadow();
    test_unused();
    test_flush();
    test_counter_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard-detection and forwarding unit for the deep-EX pipelined CPU.
- Tracks every in-flight register-writing instruction from the ID/EX register through writeback in a shift-register scoreboard.
- Tells ID to stall when a source operand is not yet producible, and selects forwarded operand data from the youngest ready producer.
- Parametrised in data width, register count and EX depth, so the split-EX pipeline (EX1/EX2 or deeper) can finally run dependent code.

Parameters:
- DATA_W, 16, operand/result width
- NUM_REGS, 16, architectural register count
- REG_AW, 4, register index width (clog2 NUM_REGS)
- EX_STAGES, 2, number of EX sub-stages (>=1)
- FLUSH_DEPTH, 1, scoreboard positions cleared on flush (1..EX_STAGES)
- DEPTH (localparam), EX_STAGES+2, tracked positions: EX1..EXn, MEM, WB
- SEL_W (localparam), clog2(DEPTH+1), forward-select width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_AW each  source register indices
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  REG_AW  destination index
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- flush  in  1  branch redirect; kills ID and young entries
- stage_data  in  DEPTH*DATA_W  result bus; slice k-1 is the value held at position k
- stall  out  1  hold PC, IF/ID and ID; insert bubble
- fwd_sel1, fwd_sel2  out  SEL_W each  0 = regfile, k = position k
- fwd_data1, fwd_data2  out  DATA_W each  selected stage_data slice; 0 when sel = 0
- stall_cycles  out  16  stall performance counter (see Optional Feature)

Behaviour:
- State: per position k (1..DEPTH), entry {valid, rd, is_load}. Reset: all valid = 0, stall_cycles = 0.
- All outputs are combinational from state and ID inputs, so with the scoreboard empty after reset: stall = 0, fwd_sel = 0, fwd_data = 0.
- Every clock, entries shift k -> k+1. The entry at DEPTH retires. There is no back-end stall.
- Position 1 insert:
  - Loads {1, id_rd, id_mem_read} when id_valid & id_reg_write & !stall & !flush.
  - Otherwise position 1 takes a bubble (valid = 0).
- Ready rule:
  - Non-load entry is ready at k >= EX_STAGES+1.
  - Load entry is ready at k >= EX_STAGES+2.
- Match for source s: id_valid & rs_used & valid[k] & rd[k] == rs.
  - Only the youngest (smallest k) match counts. Older matches are shadowed.
  - Youngest match ready: fwd_sel = k, fwd_data = stage_data slice k-1.
  - Youngest match not ready: that source requests a stall.
  - No match: sel = 0.
- stall = OR of both sources' requests, forced to 0 when flush = 1.
- While stall = 1 the fwd outputs still reflect current matching; the consumer ignores them.
- Flush:
  - Entries at positions 1..FLUSH_DEPTH are cleared, applied before the shift (i.e. they do not advance).
  - The ID instruction is not inserted.
  - flush has priority over stall.
- Consequences with EX_STAGES = 2:
  - ALU->use back-to-back gives 2 stall cycles, then fwd_sel = 3.
  - Load->use gives 3 stall cycles, then fwd_sel = 4.
- The regfile has no internal bypass, so position DEPTH (WB) forwards.
- Reset asserted mid-operation clears all entries asynchronously; stall drops immediately.

Optional Feature:
- Macro: HAZ_STALL_CNT_EN.
- Defined:
  - stall_cycles increments on every clk edge where stall = 1.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: stall_cycles is tied to 0 and no counter flops exist.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants
  - DATA_W and REG_AW defaults
  - the sb_entry_t typedef {valid, rd, is_load}
  - the FWD_REGFILE = 0 constant
- One natural sub-module: hazard_fwd_sel, the combinational youngest-match priority picker.
  - Takes one source index plus the entry array; returns sel and stall request.
  - Instantiated twice, once per source.

Test Plan:
- ALU->use: ADD r3 then ADD r5,r3,r1 (EX_STAGES=2) -> stall high 2 cycles; then fwd_sel1 = 3 and fwd_data1 = stage_data slot 2 (e.g. 16'h0042).
- Load->use: LW r4 then ADD r6,r4,r4 -> stall high 3 cycles; then fwd_sel1 = fwd_sel2 = 4.
- Shadowing: ADD r2 at pos 3 and ADD r2 at pos 1 -> stall = 1 (youngest not ready); one cycle later they are at pos 4 and pos 2 -> still stalled; next cycle fwd_sel = 3 (younger), not 5.
- Independent / unused sources: rs2_used = 0 with rs2 matching pos 1 -> stall = 0, fwd_sel2 = 0; no matches -> no stall.
- Flush during stall: producer at pos 1, consumer stalled, flush = 1 -> stall = 0 that cycle; pos 1 is cleared and does not advance, so on the next cycle pos 2 is invalid and no stall remains.
- Reset and counter (HAZ_STALL_CNT_EN defined): 5 stall cycles -> stall_cycles = 5; rst low mid-stall -> stall = 0 and stall_cycles = 0 immediately, all entries invalid.
